sc_keydebouncer: RTL
====================

SC_KEYDEBOUNCER -- requirements
Module: sc_keydebouncer

Interface
Parameters (one per line: name, default, meaning):
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the number of stable cycles needed (20 ms at 50 MHz); the legal minimum is 2.
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 20, giving the counter width; it SHALL satisfy 2^COUNT_WIDTH >= DEBOUNCE_CYCLES.

Ports (one per line: name, direction, width, meaning):
REQ-003 SC_STATEMACHINEGENERAL_CLOCK_50, input, 1, is the system clock; all state changes on its rising edge.
REQ-004 SC_STATEMACHINEGENERAL_RESET_InHigh, input, 1, is the reset: asynchronous, active-high.
REQ-005 SC_KEYDEBOUNCER_clearKey_InLow, input, 1, is the raw asynchronous clear push-button, active-low and bouncing.
REQ-006 SC_KEYDEBOUNCER_loadKey_InLow, input, 1, is the raw asynchronous load push-button, active-low and bouncing.
REQ-007 SC_KEYDEBOUNCER_clear_OutLow, output, 1, is the debounced clear level, active-low; it feeds the general state machine's clear_InLow.
REQ-008 SC_KEYDEBOUNCER_load_OutLow, output, 1, is the debounced load level, active-low; it feeds the general state machine's load_InLow.
REQ-009 SC_KEYDEBOUNCER_clearPress_Out, output, 1, is a one-cycle active-high pulse on each debounced clear press.
REQ-010 SC_KEYDEBOUNCER_loadPress_Out, output, 1, is a one-cycle active-high pulse on each debounced load press.

Function
REQ-011 The two channels (clear, load) SHALL be identical and fully independent: separate synchronizer, counter and FSM, with no shared state and no priority.
REQ-012 Each raw input SHALL pass through a two-flop synchronizer (sync1, sync2); only sync2 drives the channel logic.
REQ-013 Each channel SHALL implement a 4-state FSM: STABLE_HIGH, WAIT_LOW, STABLE_LOW, WAIT_HIGH.
REQ-014 STABLE_HIGH: sync2=0 SHALL go to WAIT_LOW with cnt cleared to 0; otherwise the FSM stays.
REQ-015 WAIT_LOW: sync2=1 SHALL return to STABLE_HIGH with cnt=0 (bounce rejected); sync2=0 with cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt; sync2=0 with cnt=DEBOUNCE_CYCLES-1 SHALL go to STABLE_LOW.
REQ-016 STABLE_LOW and WAIT_HIGH SHALL mirror REQ-014/REQ-015 with the polarity inverted, with WAIT_HIGH completing to STABLE_HIGH.
REQ-017 Level outputs SHALL be registered: *_OutLow=1 in STABLE_HIGH and WAIT_LOW, and 0 in STABLE_LOW and WAIT_HIGH; they therefore change only on the edge that completes a WAIT state.
REQ-018 *Press_Out SHALL be 1 for exactly the one cycle following the WAIT_LOW->STABLE_LOW transition, and 0 otherwise; releases SHALL produce no pulse.
REQ-019 Latency: if a raw input first samples a new level at edge k and stays stable, the level output SHALL change at edge k+DEBOUNCE_CYCLES+2, and Press_Out SHALL be high during the following cycle.
REQ-020 Any sync2 reversal before the count completes SHALL abort the wait with no output change and no pulse; the next attempt SHALL restart counting from 0.
REQ-021 The counter SHALL never wrap: it saturates by transition at DEBOUNCE_CYCLES-1 and is held at 0 in the STABLE states.
REQ-022 Simultaneous presses SHALL be debounced independently; both outputs may be low together, and priority is resolved downstream.
REQ-023 Illegal FSM encodings SHALL recover to STABLE_HIGH with outputs at 1/0 (level/pulse) on the next edge.

Reset
REQ-024 While RESET_InHigh=1, asynchronously: sync1=sync2=1, FSMs in STABLE_HIGH, cnt=0, *_OutLow=1, *Press_Out=0.
REQ-025 After reset release, a key held low SHALL be treated as a new press: the full REQ-019 latency applies, then one pulse.
REQ-026 Reset asserted mid-WAIT or mid-STABLE_LOW SHALL immediately force the REQ-024 values, with no pulse generated.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Clean clear press (clearKey 1->0, held) at edge k -> clear_OutLow=0 at edge k+6, clearPress_Out=1 for exactly one cycle, load outputs unchanged.
REQ-028 Bounce: clearKey low 3 cycles, high 1, low held -> no output change until 6 edges after the final falling sample; exactly one pulse.
REQ-029 Release: after a debounced press, clearKey 0->1 held -> clear_OutLow=1 at k+6, no pulse; a 2-cycle glitch high while pressed produces no change.
REQ-030 Both keys pressed on the same edge -> both *_OutLow fall on the same edge k+6; both pulses high in the same cycle.
REQ-031 Reset pulse asserted mid-WAIT_LOW with key still low -> outputs 1/0 immediately; after release, press recognized at release edge +6 with one pulse.
REQ-032 Held key for 50 cycles -> exactly one pulse, counter never exceeds 3, output stays 0 throughout.

Source files
------------

// File: rtl/sc_keydebouncer_if.sv
// sc_keydebouncer_if: raw key inputs and debounced level/press outputs of the key debouncer
interface sc_keydebouncer_if;
  logic clear_key_n;
  logic load_key_n;
  logic clear_n;
  logic load_n;
  logic clear_press;
  logic load_press;
  modport master (
    output clear_key_n, load_key_n,
    input  clear_n, load_n, clear_press, load_press
  );
  modport slave (
    input  clear_key_n, load_key_n,
    output clear_n, load_n, clear_press, load_press
  );
endinterface

// File: rtl/sc_keydebouncer.sv
// sc_keydebouncer: two independent synchronize-and-debounce channels for the clear and load push-buttons
module sc_keydebouncer_chan #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNT_WIDTH     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level_n,
  output logic press
);
  typedef enum logic [1:0] {STABLE_HIGH, WAIT_LOW, STABLE_LOW, WAIT_HIGH} state_t;
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic sync1, sync2, done;
  state_t state, state_nx;
  logic [COUNT_WIDTH-1:0] cnt, cnt_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      state   <= STABLE_HIGH;
      cnt     <= '0;
      level_n <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync1   <= key_n;
      sync2   <= sync1;
      state   <= state_nx;
      cnt     <= cnt_nx;
      level_n <= state_nx == STABLE_HIGH || state_nx == WAIT_LOW;
      press   <= state == WAIT_LOW && state_nx == STABLE_LOW;
    end
  // a reversal in a WAIT state aborts back to the stable state; the count only runs while waiting
  always_comb begin
    done     = cnt == LAST;
    state_nx = STABLE_HIGH;
    cnt_nx   = '0;
    case (state)
      STABLE_HIGH: state_nx = sync2 ? STABLE_HIGH : WAIT_LOW;
      WAIT_LOW: begin
        state_nx = sync2 ? STABLE_HIGH : done ? STABLE_LOW : WAIT_LOW;
        cnt_nx   = (!sync2 && !done) ? cnt + COUNT_WIDTH'(1) : '0;
      end
      STABLE_LOW:  state_nx = sync2 ? WAIT_HIGH : STABLE_LOW;
      WAIT_HIGH: begin
        state_nx = !sync2 ? STABLE_LOW : done ? STABLE_HIGH : WAIT_HIGH;
        cnt_nx   = (sync2 && !done) ? cnt + COUNT_WIDTH'(1) : '0;
      end
      default:     state_nx = STABLE_HIGH;
    endcase
  end
endmodule

module sc_keydebouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int COUNT_WIDTH     = 20
) (
  input logic SC_STATEMACHINEGENERAL_CLOCK_50,
  input logic SC_STATEMACHINEGENERAL_RESET_InHigh,
  sc_keydebouncer_if.slave bus
);
  sc_keydebouncer_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .COUNT_WIDTH(COUNT_WIDTH)) u_clear (
    .clk     (SC_STATEMACHINEGENERAL_CLOCK_50),
    .rst     (SC_STATEMACHINEGENERAL_RESET_InHigh),
    .key_n   (bus.clear_key_n),
    .level_n (bus.clear_n),
    .press   (bus.clear_press)
  );
  sc_keydebouncer_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .COUNT_WIDTH(COUNT_WIDTH)) u_load (
    .clk     (SC_STATEMACHINEGENERAL_CLOCK_50),
    .rst     (SC_STATEMACHINEGENERAL_RESET_InHigh),
    .key_n   (bus.load_key_n),
    .level_n (bus.load_n),
    .press   (bus.load_press)
  );
endmodule
